// File: rtl/cnn_pkg.sv
// Shared fixed-point CNN definitions: word geometry, MAC FSM states, Q5.10 constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

  // Q5.10 signed words, 5x5 windows, 40-bit signed accumulation
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 10;
  localparam int BLOCK_SIZE = 25;
  localparam int ACC_WIDTH  = 40;

  // Job sequencing of the serial MAC engine
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Q5.10 reference values
  localparam logic [DATA_WIDTH-1:0] Q_ONE = 16'h0400;
  localparam logic [DATA_WIDTH-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_WIDTH-1:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/fx_round_sat.sv
// Adds a bias to a wide accumulator, rounds half toward +inf, drops FRAC_BITS, saturates, optional ReLU.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result when it needs it.
module fx_round_sat
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS,
  parameter int ACC_WIDTH  = cnn_pkg::ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         relu_en,
  output logic        [DATA_WIDTH-1:0] result
);

  // Two guard bits so acc + aligned bias + half LSB can never wrap
  localparam int SUM_W = ACC_WIDTH + 2;

  localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_WIDTH - 1)));

  logic signed [SUM_W-1:0]      acc_ext;
  logic signed [SUM_W-1:0]      bias_ext;
  logic signed [SUM_W-1:0]      sum;
  logic signed [SUM_W-1:0]      shifted;
  logic        [DATA_WIDTH-1:0] sat;

  // Bias is aligned to the accumulator's 2*FRAC_BITS binary point before adding
  assign acc_ext  = SUM_W'(acc);
  assign bias_ext = SUM_W'(bias) <<< FRAC_BITS;
  assign sum      = acc_ext + bias_ext + HALF;
  assign shifted  = sum >>> FRAC_BITS;

  // Clamp to the representable word range, then zero negatives when ReLU is on
  always_comb begin
    sat = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    result = (relu_en && sat[DATA_WIDTH-1]) ? '0 : sat;
  end

endmodule

// File: rtl/conv_window_mac.sv
// Serial MAC over one 5x5 window and kernel plus bias, producing one rounded/saturated/ReLU'd pixel.
// Latency: accept edge 0, products on edges 1..25, result valid from edge 26; one job per 28 cycles at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, stalling indefinitely.
module conv_window_mac #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = cnn_pkg::FRAC_BITS,
  parameter int BLOCK_SIZE = cnn_pkg::BLOCK_SIZE,
  parameter int ACC_WIDTH  = cnn_pkg::ACC_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] window_in,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] kernel_in,
  input  logic [DATA_WIDTH-1:0]            bias_in,
  input  logic                             relu_en,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  import cnn_pkg::*;

  localparam int               IDX_W    = $clog2(BLOCK_SIZE);
  localparam int               PROD_W   = 2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic signed [ACC_WIDTH-1:0]  acc;

  // Private copies of the job so upstream may move on right after the accept
  logic signed [DATA_WIDTH-1:0] win_q [BLOCK_SIZE];
  logic signed [DATA_WIDTH-1:0] ker_q [BLOCK_SIZE];
  logic signed [DATA_WIDTH-1:0] bias_q;
  logic                         relu_q;

  logic signed [DATA_WIDTH-1:0] win_cur;
  logic signed [DATA_WIDTH-1:0] ker_cur;
  logic signed [PROD_W-1:0]     prod;
  logic        [DATA_WIDTH-1:0] result;
  logic                         accept;

  // in_ready is gated by rst so nothing is offered while reset is held
  assign in_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;

  // One shared multiplier, stepped through the window by idx
  assign win_cur = win_q[idx];
  assign ker_cur = ker_q[idx];
  assign prod    = win_cur * ker_cur;

  fx_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_round_sat (
    .acc     (acc),
    .bias    (bias_q),
    .relu_en (relu_q),
    .result  (result)
  );

  // Capture window, kernel, bias and ReLU mode on the accepting edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        win_q[i] <= '0;
        ker_q[i] <= '0;
      end
      bias_q <= '0;
      relu_q <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        win_q[i] <= window_in[i*DATA_WIDTH +: DATA_WIDTH];
        ker_q[i] <= kernel_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      bias_q <= bias_in;
      relu_q <= relu_en;
    end
  end

  // Job FSM: accumulate BLOCK_SIZE products, register the rounded result, hold it until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= '0;
            idx   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          // 25 products of at most 2^30 fit in 40 signed bits, so no wrap guard
          acc <= acc + ACC_WIDTH'(prod);
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ST_ROUND;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_ROUND: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Serial fixed-point multiply-accumulate engine that consumes one 5x5 data window (25 words, the DMA read block) plus a matching 25-word kernel and bias, and produces one rounded, saturated, optionally ReLU'd output pixel. Sits directly downstream of the DMA read path and upstream of the feature-map write-back. Uses a valid/ready handshake on both sides and one multiplier, time-shared over 25 cycles.

## Interface
Parameters:
- DATA_WIDTH, 16: word width, signed two's complement, Q5.10 (0x0400 = 1.0)
- FRAC_BITS, 10: fractional bits of every data, kernel and output word
- BLOCK_SIZE, 25: words per window and per kernel
- ACC_WIDTH, 40: accumulator width, signed

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- window_in  in  DATA_WIDTH*BLOCK_SIZE  flattened window; word i at [i*DATA_WIDTH +: DATA_WIDTH]
- kernel_in  in  DATA_WIDTH*BLOCK_SIZE  flattened kernel, same packing
- bias_in  in  DATA_WIDTH  bias, Q5.10
- relu_en  in  1  clamp negative results to 0
- in_valid  in  1  window/kernel/bias/relu_en valid
- in_ready  out  1  block can accept a new job
- out_data  out  DATA_WIDTH  result, Q5.10
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  job in progress (MAC, ROUND or DONE)

## Operation
- States: IDLE, MAC, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture all inputs into internal registers, clear accumulator, index=0, go MAC. Inputs may change freely after capture.
- MAC: each cycle acc += sext(win[index]*ker[index]); product is full 32-bit signed. index 0..24; after index 24 go ROUND.
- ROUND: sum = acc + (sext(bias) << FRAC_BITS) + (1 << (FRAC_BITS-1)); shifted = sum >>> FRAC_BITS (arithmetic, round half toward +inf). Saturate to [-32768, 32767] → 0x8000 / 0x7FFF. If relu_en and result negative → 0x0000. Register into out_data, out_valid=1, go DONE.
- DONE: hold out_data and out_valid stable until out_valid&&out_ready; then out_valid=0, go IDLE.
- in_ready=0 in every state except IDLE; a new job is never accepted while a result is pending.
- Accumulator cannot overflow at 40 bits (25 × 2^30 < 2^39); no internal wrap handling.

## Timing
- Reset values: out_data=0x0000, out_valid=0, busy=0, state=IDLE, acc=0, index=0; in_ready forced 0 while rst high, 1 the cycle after release.
- Accept edge = edge 0. Edges 1..25 accumulate products 0..24. Edge 26 registers result: out_valid high from edge 26.
- With out_ready held high: handshake at edge 27, in_ready high after edge 27, next accept earliest edge 28 → one result per 28 cycles.
- out_ready low: stall indefinitely in DONE, out_data unchanged.
- out_ready high before out_valid: no effect.
- rst asserted mid-job (any state): job discarded immediately, all outputs to reset values, no partial result emitted.

## Structure
- Shared package cnn_pkg: DATA_WIDTH, FRAC_BITS, BLOCK_SIZE, ACC_WIDTH, state enum type, Q5.10 constants (ONE=0x0400, MAX=0x7FFF, MIN=0x8000).
- One sub-module: fx_round_sat (combinational: acc + bias in, rounding, shift, saturation, ReLU → DATA_WIDTH out), reused later by the pooling stage.
- Top holds FSM, capture registers, index counter, multiplier, accumulator.

## Test plan
- All window words 0x0400, kernel 0x0400, bias 0, relu_en 0 → out_data 0x6400 (25.0) with out_valid at edge 26 after accept.
- Window 0x2000, kernel 0x2000 (8.0×8.0×25=1600) → 0x7FFF; kernel 0xE000 → 0x8000.
- Window 0x0400, kernel 0xFC00, bias 0: relu_en 0 → 0x9C00 (−25.0); relu_en 1 → 0x0000.
- Rounding: win[0]=0x0001, ker[0]=0x0200, rest 0, bias 0 → 0x0001; ker[0]=0x01FF → 0x0000; bias 0x0400 added → 0x0401.
- Backpressure: out_ready low 10 cycles after out_valid → out_data stable, in_ready 0, in_valid ignored; release → handshake, in_ready 1 next cycle.
- rst pulsed at edge 12 of MAC → out_valid never asserts, outputs at reset values; fresh job after release yields correct result.
